// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, frame bit
// levels and the default inter-edge timeout.
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic FRAME_START = 1'b0;
    localparam logic FRAME_STOP  = 1'b1;

    localparam int PS2_TIMEOUT_DEFAULT = 20000;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: head byte visible combinationally, sticky overflow
// flag set whenever a push is dropped because the buffer is full.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;
    logic w_drop;

    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_data     = r_mem[r_rd_ptr];
    assign o_overflow = r_overflow;

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~w_full | w_pop_ok);
    assign w_drop    = i_push & w_full & ~w_pop_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)        r_overflow <= 1'b1;
            else if (w_pop_ok) r_overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronizes the pins, deframes 11-bit frames
// and buffers good scan-code bytes in a show-ahead FIFO for MMIO reads.
//
// state     | meaning
// ST_IDLE   | waiting for a start bit on a PS/2 clock fall
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the odd-parity bit
// ST_STOP   | checking stop bit and parity, then push or flag error
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = PS2_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       read_enable,
    output logic       ready,
    output logic       overflow,
    output logic [7:0] data,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic          r_clk_s1, r_clk_s2, r_clk_prev;
    logic          r_data_s1, r_data_s2;
    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [TW-1:0] r_tmo;
    logic          r_frame_err;

    logic w_fall;
    logic w_good;
    logic w_push;
    logic w_empty;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_good    = (r_data_s2 == FRAME_STOP) & odd_parity_ok(r_shift, r_parity);
    assign w_push    = (r_state == ST_STOP) & w_fall & w_good;
    assign ready     = ~w_empty;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_s1   <= 1'b1;
            r_data_s2   <= 1'b1;
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tmo       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_clk_s1    <= ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_clk_prev  <= r_clk_s2;
            r_data_s1   <= ps2_data;
            r_data_s2   <= r_data_s1;
            r_frame_err <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_fall && r_data_s2 == FRAME_START) begin
                    r_state   <= ST_DATA;
                    r_bit_cnt <= '0;
                    r_tmo     <= TW'(TIMEOUT - 1);
                end
            end else if (w_fall) begin
                r_tmo <= TW'(TIMEOUT - 1);
                case (r_state)
                    ST_DATA: begin
                        r_shift   <= {r_data_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        r_parity <= r_data_s2;
                        r_state  <= ST_STOP;
                    end
                    default: begin
                        r_frame_err <= ~w_good;
                        r_state     <= ST_IDLE;
                    end
                endcase
            end else if (r_tmo == '0) begin
                // Device stalled mid-frame: abandon it so the next start bit resyncs.
                r_frame_err <= 1'b1;
                r_state     <= ST_IDLE;
            end else begin
                r_tmo <= r_tmo - 1'b1;
            end
        end
    end

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (r_shift),
        .i_pop       (read_enable),
        .o_data      (data),
        .o_empty     (w_empty),
        .o_overflow  (overflow)
    );

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: a queue-based model of the receive
// buffer checked every cycle, plus hand-computed literal expectations.
module tb_ps2_keyboard;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 200;
    localparam int HALF    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       read_enable = 1'b0;
    logic       ready;
    logic       overflow;
    logic [7:0] data;
    logic       frame_err;

    ps2_keyboard #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .read_enable (read_enable),
        .ready       (ready),
        .overflow    (overflow),
        .data        (data),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    bit         m_ovf = 0;
    bit         m_ferr = 0;
    bit         ferr_dc = 0;
    bit         chk_en = 0;
    int         push_cd = 0;
    logic [7:0] push_val;
    bit         push_good;
    int         ferr_seen = 0;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clk; apply to the model whatever the DUT commits on this edge.
    task automatic tick();
        bit pop_ok, push_now, full, discard;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_ovf   = 0;
            m_ferr  = 0;
            push_cd = 0;
        end else begin
            pop_ok   = read_enable && q.size() != 0;
            push_now = 0;
            m_ferr   = 0;
            if (push_cd > 0) begin
                push_cd--;
                if (push_cd == 0) begin
                    if (push_good) push_now = 1;
                    else           m_ferr   = 1;
                end
            end
            full    = (q.size() == DEPTH);
            discard = push_now && full && !pop_ok;
            if (pop_ok) void'(q.pop_front());
            if (push_now && !discard) q.push_back(push_val);
            if (discard)     m_ovf = 1;
            else if (pop_ok) m_ovf = 0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("ready", ready, q.size() != 0);
            check("overflow", overflow, m_ovf);
            if (q.size() != 0) check("data", data, q[0]);
            if (!ferr_dc) check("frame_err", frame_err, m_ferr);
            if (frame_err) ferr_seen++;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop_one();
        read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
    endtask

    // Frame outcome is known from its content; it lands 3 clk edges after the stop fall.
    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop_v,
                              input int nbits, input bit pop_sync);
        logic       par;
        logic [10:0] bits;
        par  = ~(^b) ^ par_flip;
        bits = {stop_v, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            idle(HALF);
            ps2_clk = 1'b0;
            if (i == 10) begin
                push_cd   = 3;
                push_val  = b;
                push_good = stop_v && (^{b, par});
            end
            for (int k = 0; k < HALF; k++) begin
                if (pop_sync && i == 10 && k == 2) read_enable = 1'b1;
                tick();
                read_enable = 1'b0;
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        idle(4);
    endtask

    initial begin
        idle(3);
        check("rst_ready", ready, 0);
        check("rst_overflow", overflow, 0);
        check("rst_data", data, 8'h00);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        chk_en = 1;
        idle(4);

        // good frame 0x1C
        ferr_seen = 0;
        send_frame(8'h1C, 0, 1, 11, 0);
        check("good_ready", ready, 1);
        check("good_data", data, 8'h1C);
        check("good_no_ferr", ferr_seen, 0);
        pop_one();
        check("good_popped", ready, 0);
        pop_one();
        check("empty_pop_ignored", ready, 0);

        // bad parity
        ferr_seen = 0;
        send_frame(8'h1C, 1, 1, 11, 0);
        check("parity_ferr", ferr_seen, 1);
        check("parity_ready", ready, 0);

        // bad stop bit
        ferr_seen = 0;
        send_frame(8'h1C, 0, 0, 11, 0);
        check("stop_ferr", ferr_seen, 1);
        check("stop_ready", ready, 0);

        // overflow: DEPTH+1 frames, no reads
        for (int v = 1; v <= DEPTH + 1; v++) send_frame(8'(v), 0, 1, 11, 0);
        check("ovf_set", overflow, 1);
        for (int v = 1; v <= DEPTH; v++) begin
            check("ovf_read", data, v);
            pop_one();
            if (v == 1) check("ovf_clear", overflow, 0);
        end
        check("ovf_drained", ready, 0);

        // push and pop together while full
        for (int v = 0; v < DEPTH; v++) send_frame(8'h11 + 8'(v), 0, 1, 11, 0);
        send_frame(8'hF0, 0, 1, 11, 1);
        check("full_pp_ovf", overflow, 0);
        for (int v = 0; v < DEPTH; v++) begin
            check("full_pp_read", data, (v == DEPTH - 1) ? 32'hF0 : 32'h12 + v);
            pop_one();
        end
        check("full_pp_drained", ready, 0);

        // timeout after 4 data bits
        ferr_seen = 0;
        ferr_dc   = 1;
        send_frame(8'hA5, 0, 1, 5, 0);
        for (int n = 0; n < TIMEOUT + 40 && ferr_seen == 0; n++) tick();
        idle(4);
        check("timeout_ferr", ferr_seen, 1);
        ferr_dc = 0;
        send_frame(8'hF0, 0, 1, 11, 0);
        check("after_tmo_data", data, 8'hF0);
        check("after_tmo_ferr", ferr_seen, 1);
        pop_one();

        // reset mid-frame with a non-empty FIFO
        send_frame(8'h5A, 0, 1, 11, 0);
        check("pre_rst_ready", ready, 1);
        ferr_seen = 0;
        send_frame(8'h3C, 0, 1, 5, 0);
        rst = 1'b1;
        idle(2);
        check("midrst_ready", ready, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_data", data, 8'h00);
        check("midrst_frame_err", frame_err, 0);
        rst = 1'b0;
        idle(4);
        send_frame(8'h2B, 0, 1, 11, 0);
        check("post_rst_ready", ready, 1);
        check("post_rst_data", data, 8'h2B);
        check("post_rst_ferr", ferr_seen, 0);
        pop_one();
        idle(4);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
